// File: rtl/wb_model_pkg.sv
// Shared types and constants for the Wishbone latency memory model.
//   state_t        : responder FSM states
//   LFSR_POLY      : Galois tap mask for x^16+x^14+x^13+x^11+1
//   lane_mask()    : expands byte selects into a per-bit write mask
package wb_model_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Widest supported bus: 32 byte lanes (256-bit data)
    localparam int unsigned MAX_LANES = 32;

    // Each select bit enables all eight bits of its byte lane
    function automatic logic [MAX_LANES*8-1:0] lane_mask(input logic [MAX_LANES-1:0] sel);
        logic [MAX_LANES*8-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            mask[i*8 +: 8] = {8{sel[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_lfsr16.sv
// 16-bit Galois LFSR, advancing every cycle outside reset.
//   clk : clock
//   rst : synchronous active-high reset, loads SEED
//   out : current LFSR state
module wb_lfsr16
    import wb_model_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= SEED;
        end else begin
            out <= {1'b0, out[15:1]} ^ (out[0] ? LFSR_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/wb_latency_mem.sv
// Wishbone classic slave memory with bounded fixed or pseudo-random wait
// states, byte-lane writes, abort detection and transaction statistics.
//   clk, rst             : clock, synchronous active-high reset
//   bus__cyc/stb/we/sel  : Wishbone request qualifiers
//   bus__adr, bus__dat_w : word address (upper bits alias), write data
//   bus__dat_r, bus__ack : read data (zero when not acking), acknowledge
//   txn_count            : completed transactions (wraps)
//   max_wait_seen        : largest wait count of a completed transaction
//   abort_count          : transactions abandoned before completion (saturates)
module wb_latency_mem
    import wb_model_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 30,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned MIN_WAIT   = 1,
    parameter int unsigned MAX_WAIT   = 7,
    parameter int unsigned RANDOM     = 1,
    parameter logic [15:0] LFSR_SEED  = LFSR_DEFAULT_SEED
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bus__cyc,
    input  logic                bus__stb,
    input  logic                bus__we,
    input  logic [DATA_W/8-1:0] bus__sel,
    input  logic [ADDR_W-1:0]   bus__adr,
    input  logic [DATA_W-1:0]   bus__dat_w,
    output logic [DATA_W-1:0]   bus__dat_r,
    output logic                bus__ack,
    output logic [31:0]         txn_count,
    output logic [7:0]          max_wait_seen,
    output logic [15:0]         abort_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned SPAN  = MAX_WAIT - MIN_WAIT + 1;

    // Parameter sanity, evaluated at elaboration
    if (MIN_WAIT < 1) begin : g_chk_min
        $fatal(1, "wb_latency_mem: MIN_WAIT must be >= 1");
    end
    if (MAX_WAIT < MIN_WAIT || MAX_WAIT > 255) begin : g_chk_max
        $fatal(1, "wb_latency_mem: MAX_WAIT must be in [MIN_WAIT, 255]");
    end
    if (LFSR_SEED == 16'h0000) begin : g_chk_seed
        $fatal(1, "wb_latency_mem: LFSR_SEED must be nonzero");
    end
    if ((DATA_W % 8) != 0 || (DATA_W / 8) > MAX_LANES) begin : g_chk_dw
        $fatal(1, "wb_latency_mem: DATA_W must be a multiple of 8 up to 256");
    end
    if (DEPTH_LOG2 > ADDR_W) begin : g_chk_depth
        $fatal(1, "wb_latency_mem: DEPTH_LOG2 must not exceed ADDR_W");
    end
    if (RANDOM != 0 && (SPAN & (SPAN - 1)) != 0) begin : g_chk_span
        $fatal(1, "wb_latency_mem: MAX_WAIT-MIN_WAIT+1 must be a power of two");
    end

    state_t                  state, state_nxt;
    logic [7:0]              cnt, cnt_nxt;
    logic [7:0]              wait_lat, wait_lat_nxt;
    logic [7:0]              wait_sel_c;
    logic                    req_c;
    logic                    commit_c;
    logic                    abort_c;
    logic [15:0]             lfsr;
    logic [DATA_W-1:0]       wmask_c;
    logic [DEPTH_LOG2-1:0]   widx_c;
    logic [DATA_W-1:0]       mem [DEPTH];

    wb_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (lfsr)
    );

    assign req_c   = bus__cyc & bus__stb;
    assign widx_c  = bus__adr[DEPTH_LOG2-1:0];
    assign wmask_c = DATA_W'(lane_mask(MAX_LANES'(bus__sel)));

    // Low LFSR bits pick an offset inside the power-of-two wait span
    assign wait_sel_c = (RANDOM != 0)
                      ? 8'(MIN_WAIT) + (lfsr[7:0] & 8'(SPAN - 1))
                      : 8'(MIN_WAIT);

    // Upper address bits alias by design; upper LFSR bits only feed the taps
    logic unused_bits;
    assign unused_bits = ^{bus__adr, lfsr};

    // Next-state logic and completion/abort strobes
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        wait_lat_nxt = wait_lat;
        commit_c     = 1'b0;
        abort_c      = 1'b0;
        case (state)
            IDLE: begin
                if (req_c) begin
                    wait_lat_nxt = wait_sel_c;
                    cnt_nxt      = wait_sel_c - 8'd1;
                    state_nxt    = (wait_sel_c == 8'd1) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!req_c) begin
                    state_nxt = IDLE;
                    abort_c   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                    if (cnt_nxt == 8'd0) begin
                        state_nxt = ACK;
                    end
                end
            end
            ACK: begin
                state_nxt = IDLE;
                if (req_c) begin
                    commit_c = 1'b1;
                end else begin
                    abort_c = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, outputs and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            wait_lat      <= 8'd0;
            bus__ack      <= 1'b0;
            bus__dat_r    <= '0;
            txn_count     <= 32'd0;
            max_wait_seen <= 8'd0;
            abort_count   <= 16'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            wait_lat <= wait_lat_nxt;
            bus__ack <= (state_nxt == ACK);
            // Read data is fetched on entry to ACK so it lines up with ack
            if (state_nxt == ACK && !bus__we) begin
                bus__dat_r <= mem[widx_c];
            end else begin
                bus__dat_r <= '0;
            end
            if (commit_c) begin
                txn_count <= txn_count + 32'd1;
                if (wait_lat > max_wait_seen) begin
                    max_wait_seen <= wait_lat;
                end
            end
            if (abort_c && abort_count != 16'hFFFF) begin
                abort_count <= abort_count + 16'd1;
            end
        end
    end

    // Storage is never reset; writes land only on a completed ACK cycle
    always_ff @(posedge clk) begin
        if (!rst && commit_c && bus__we) begin
            mem[widx_c] <= (mem[widx_c] & ~wmask_c) | (bus__dat_w & wmask_c);
        end
    end

endmodule

// File: tb/tb_wb_latency_mem.sv
// Directed bench for wb_latency_mem: three instances (fixed W=3, random
// W in [1,8], fixed W=5) checked against a word model and an LFSR model.
module tb_wb_latency_mem;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst   [N];
    logic        cyc   [N];
    logic        stb   [N];
    logic        we    [N];
    logic [3:0]  sel   [N];
    logic [29:0] adr   [N];
    logic [31:0] dat_w [N];
    logic [31:0] dat_r [N];
    logic        ack   [N];
    logic [31:0] txn   [N];
    logic [7:0]  mws   [N];
    logic [15:0] abt   [N];

    always #5 clk = ~clk;

    wb_latency_mem #(.MIN_WAIT(3), .MAX_WAIT(3), .RANDOM(0)) u_fix3 (
        .clk(clk), .rst(rst[0]), .bus__cyc(cyc[0]), .bus__stb(stb[0]), .bus__we(we[0]),
        .bus__sel(sel[0]), .bus__adr(adr[0]), .bus__dat_w(dat_w[0]), .bus__dat_r(dat_r[0]),
        .bus__ack(ack[0]), .txn_count(txn[0]), .max_wait_seen(mws[0]), .abort_count(abt[0]));

    wb_latency_mem #(.MIN_WAIT(1), .MAX_WAIT(8), .RANDOM(1)) u_rnd (
        .clk(clk), .rst(rst[1]), .bus__cyc(cyc[1]), .bus__stb(stb[1]), .bus__we(we[1]),
        .bus__sel(sel[1]), .bus__adr(adr[1]), .bus__dat_w(dat_w[1]), .bus__dat_r(dat_r[1]),
        .bus__ack(ack[1]), .txn_count(txn[1]), .max_wait_seen(mws[1]), .abort_count(abt[1]));

    wb_latency_mem #(.MIN_WAIT(5), .MAX_WAIT(5), .RANDOM(0)) u_fix5 (
        .clk(clk), .rst(rst[2]), .bus__cyc(cyc[2]), .bus__stb(stb[2]), .bus__we(we[2]),
        .bus__sel(sel[2]), .bus__adr(adr[2]), .bus__dat_w(dat_w[2]), .bus__dat_r(dat_r[2]),
        .bus__ack(ack[2]), .txn_count(txn[2]), .max_wait_seen(mws[2]), .abort_count(abt[2]));

    // Reference Galois LFSR for the random instance
    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (rst[1]) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    typedef struct {
        int          lat;
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] mmem [N][1024];
    int          exp_txn [N];
    int          n_vec = 0;
    int          n_mis = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One held transaction; called and returns #1 after a rising edge
    task automatic txn_run(input int k, input logic w, input logic [29:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output int lat, output logic [31:0] rd);
        exp_t e;
        int   word;
        word  = int'(a[9:0]);
        e.lat = (k == 0) ? 3 : (k == 2) ? 5 : 1 + int'(m_lfsr[2:0]);
        e.dat = w ? 32'h0 : mmem[k][word];
        exp_q.push_back(e);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; dat_w[k] = d; sel[k] = s;
        check("ack_in_request_cycle", 64'(ack[k]), 64'd0);
        lat = 0;
        while (!ack[k] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ack_timeout", 64'(ack[k]), 64'd1);
        rd = dat_r[k];
        e  = exp_q.pop_front();
        check("ack_latency", 64'(lat), 64'(e.lat));
        check("dat_r", 64'(rd), 64'(e.dat));
        if (w) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) mmem[k][word][i*8 +: 8] = d[i*8 +: 8];
            end
        end
        exp_txn[k]++;
        @(posedge clk); #1;
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
        check("ack_one_cycle", 64'(ack[k]), 64'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic [8:0]  hit;
        int          guard;
        logic        any_ack;

        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            sel[k] = 4'h0; adr[k] = 30'h0; dat_w[k] = 32'h0; exp_txn[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            check("reset_ack", 64'(ack[k]), 64'd0);
            check("reset_dat_r", 64'(dat_r[k]), 64'd0);
            check("reset_txn", 64'(txn[k]), 64'd0);
            check("reset_max_wait", 64'(mws[k]), 64'd0);
            check("reset_abort", 64'(abt[k]), 64'd0);
            rst[k] = 1'b0;
        end

        // Fixed W=3: read-after-write at word 5
        txn_run(0, 1'b1, 30'd5, 32'hCAFEF00D, 4'hF, lat, rd);
        txn_run(0, 1'b0, 30'd5, 32'h0, 4'h0, lat, rd);
        check("fix3_read_latency", 64'(lat), 64'd3);
        check("fix3_read_data", 64'(rd), 64'hCAFEF00D);
        check("fix3_txn", 64'(txn[0]), 64'd2);
        check("fix3_max_wait", 64'(mws[0]), 64'd3);

        // Byte-lane write over a zeroed word
        txn_run(0, 1'b1, 30'd2, 32'h0, 4'hF, lat, rd);
        txn_run(0, 1'b1, 30'd2, 32'hDEADBEEF, 4'b0101, lat, rd);
        txn_run(0, 1'b0, 30'd2, 32'h0, 4'h0, lat, rd);
        check("lane_write_data", 64'(rd), 64'h00AD00EF);

        // Address aliasing: 0x401 lands on word 1
        txn_run(0, 1'b1, 30'h401, 32'h12345678, 4'hF, lat, rd);
        txn_run(0, 1'b0, 30'h001, 32'h0, 4'h0, lat, rd);
        check("alias_data", 64'(rd), 64'h12345678);

        // Master drops the request in the ack cycle: ack still given, no write
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 30'd5;
        dat_w[0] = 32'hFFFFFFFF; sel[0] = 4'hF;
        repeat (3) begin @(posedge clk); #1; end
        check("ackabort_ack", 64'(ack[0]), 64'd1);
        check("ackabort_dat_r", 64'(dat_r[0]), 64'd0);
        cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        @(posedge clk); #1;
        check("ackabort_abort", 64'(abt[0]), 64'd1);
        check("ackabort_txn", 64'(txn[0]), 64'(exp_txn[0]));
        txn_run(0, 1'b0, 30'd5, 32'h0, 4'h0, lat, rd);
        check("ackabort_mem_kept", 64'(rd), 64'hCAFEF00D);

        // Fixed W=5: strobe dropped in cycle 2 of a write
        txn_run(2, 1'b1, 30'd7, 32'h11111111, 4'hF, lat, rd);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 30'd7;
        dat_w[2] = 32'hFFFFFFFF; sel[2] = 4'hF;
        @(posedge clk); #1;
        check("abort_cycle1_ack", 64'(ack[2]), 64'd0);
        @(posedge clk); #1;
        stb[2] = 1'b0;
        any_ack = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            any_ack = any_ack | ack[2];
        end
        check("abort_no_ack", 64'(any_ack), 64'd0);
        check("abort_count", 64'(abt[2]), 64'd1);
        check("abort_txn_unchanged", 64'(txn[2]), 64'd1);
        cyc[2] = 1'b0; we[2] = 1'b0;
        txn_run(2, 1'b0, 30'd7, 32'h0, 4'h0, lat, rd);
        check("abort_mem_unchanged", 64'(rd), 64'h11111111);

        // Random wait states in [1,8]
        for (int a = 0; a < 8; a++) begin
            txn_run(1, 1'b1, 30'(a), $urandom, 4'hF, lat, rd);
        end
        hit = '0;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            txn_run(1, 1'b0, 30'($urandom_range(0, 7)), 32'h0, 4'h0, lat, rd);
            check("rnd_latency_range", 64'(lat >= 1 && lat <= 8), 64'd1);
            if (lat >= 1 && lat <= 8) hit[lat] = 1'b1;
        end
        check("rnd_all_latencies_hit", 64'(hit[8:1]), 64'hFF);
        check("rnd_txn", 64'(txn[1]), 64'd1008);
        check("rnd_max_wait", 64'(mws[1]), 64'd8);
        check("rnd_abort", 64'(abt[1]), 64'd0);

        // Reset while in WAIT: wait for a draw with W >= 3
        guard = 0;
        while (m_lfsr[2:0] < 3'd2 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 30'd0;
        @(posedge clk); #1;
        check("rstwait_cycle1_ack", 64'(ack[1]), 64'd0);
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        exp_txn[1] = 0;
        check("rstwait_ack", 64'(ack[1]), 64'd0);
        check("rstwait_dat_r", 64'(dat_r[1]), 64'd0);
        check("rstwait_txn", 64'(txn[1]), 64'd0);
        check("rstwait_max_wait", 64'(mws[1]), 64'd0);
        check("rstwait_abort", 64'(abt[1]), 64'd0);
        // Seed 0xACE1 gives offset 1, so the first request waits 2 cycles
        txn_run(1, 1'b0, 30'd0, 32'h0, 4'h0, lat, rd);
        check("rstwait_seed_latency", 64'(lat), 64'd2);
        check("rstwait_txn_after", 64'(txn[1]), 64'd1);
        check("rstwait_max_after", 64'(mws[1]), 64'd2);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
